// File: rtl/crc32_pkg.sv
// Shared CRC32 definitions: reflected IEEE 802.3 polynomial, residue,
// per-frame mode encodings and the single-byte LSB-first update.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    MODE_COMPUTE = 2'd0,
    MODE_APPEND  = 2'd1,
    MODE_CHECK   = 2'd2,
    MODE_BYPASS  = 2'd3
  } crc_mode_e;

  // One byte through the reflected CRC register, bit 0 of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_axis_param_if.sv
// AXI-Stream bundle carrying the CRC side-band (tuser = final CRC, crc_err).
// The slave view omits the side-band, which only exists on the output side.
interface crc32_axis_param_if #(
  parameter int DATA_W = 64
) ();
  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tready;
  logic [31:0]       tuser;
  logic              crc_err;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, crc_err, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/crc32_comb_update.sv
// Purely combinational CRC32 update over KEEP_W bytes; bytes whose keep bit
// is clear are skipped. Byte 0 is processed first.
module crc32_comb_update
  import crc32_pkg::*;
#(
  parameter int KEEP_W = 8
) (
  input  logic [31:0]         crc_in,
  input  logic [8*KEEP_W-1:0] data,
  input  logic [KEEP_W-1:0]   keep,
  output logic [31:0]         crc_out
);

  // Chain the enabled bytes through the byte update in wire order.
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < KEEP_W; i++) begin
      if (keep[i]) crc_out = crc32_byte(crc_out, data[8*i +: 8]);
    end
  end

endmodule

// File: rtl/crc32_axis_param.sv
// Parametrised AXI-Stream CRC32 engine: compute / append FCS / check FCS /
// bypass per frame, one registered output stage, saturating statistics.
module crc32_axis_param
  import crc32_pkg::*;
#(
  parameter int          DATA_W  = 64,
  parameter logic [31:0] RESIDUE = CRC32_RESIDUE,
  parameter int          CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  crc32_axis_param_if.slave    s_axis,
  crc32_axis_param_if.master   m_axis,
  input  logic [1:0]           cfg_mode,
  input  logic [31:0]          crc_init,
  output logic [CNT_W-1:0]     stat_frames,
  output logic [CNT_W-1:0]     stat_errs
);

  localparam int KEEP_W = DATA_W / 8;

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_EXTRA  = 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [KEEP_W-1:0] keep_mask(input int n);
    logic [KEEP_W-1:0] m;
    for (int i = 0; i < KEEP_W; i++) m[i] = (i < n);
    return m;
  endfunction

  // Frame control state
  logic [0:0]  state_q;
  logic        sof_q;
  crc_mode_e   mode_q;
  logic [31:0] crc_q;
  logic [31:0] fcs_q;
  logic [2:0]  rem_q;

  // Output register stage
  logic [DATA_W-1:0] data_p1;
  logic [KEEP_W-1:0] keep_p1;
  logic              last_p1;
  logic [31:0]       user_p1;
  logic              err_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  frames_q;
  logic [CNT_W-1:0]  errs_q;

  logic        out_free;
  logic        accept;
  crc_mode_e   cur_mode;
  logic [31:0] crc_base;
  logic [31:0] crc_upd;
  logic [31:0] fcs;
  int          n_bytes;

  logic [DATA_W-1:0] ld_data;
  logic [KEEP_W-1:0] ld_keep;
  logic              ld_last;
  logic [31:0]       ld_user;
  logic              ld_err;
  logic              ld_split;
  logic [2:0]        ld_rem;
  logic [DATA_W-1:0] extra_data;
  logic [KEEP_W-1:0] extra_keep;

  assign out_free      = !vld_p1 || m_axis.tready;
  assign s_axis.tready = out_free && (state_q == ST_NORMAL) && !rst;
  assign accept        = s_axis.tvalid && s_axis.tready;

  // First beat of a frame works from the live config; later beats from the latch.
  assign cur_mode = sof_q ? crc_mode_e'(cfg_mode) : mode_q;
  assign crc_base = sof_q ? crc_init : crc_q;

  crc32_comb_update #(.KEEP_W(KEEP_W)) u_update (
    .crc_in  (crc_base),
    .data    (s_axis.tdata),
    .keep    (s_axis.tkeep),
    .crc_out (crc_upd)
  );

  assign fcs = ~crc_upd;

  // Count valid bytes on the incoming beat (tkeep = 0 gives n = 0).
  always_comb begin
    n_bytes = 0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (s_axis.tkeep[i]) n_bytes = n_bytes + 1;
    end
  end

  // Build the output beat for an accepted input, inserting FCS bytes when appending.
  always_comb begin
    ld_data  = s_axis.tdata;
    ld_keep  = s_axis.tkeep;
    ld_last  = s_axis.tlast;
    ld_user  = '0;
    ld_err   = 1'b0;
    ld_split = 1'b0;
    ld_rem   = '0;
    if (s_axis.tlast) begin
      case (cur_mode)
        MODE_COMPUTE: ld_user = fcs;
        MODE_CHECK: begin
          ld_user = fcs;
          ld_err  = (crc_upd != RESIDUE);
        end
        MODE_APPEND: begin
          for (int i = 0; i < KEEP_W; i++) begin
            if (i >= n_bytes && i < n_bytes + 4) ld_data[8*i +: 8] = fcs[8*(i-n_bytes) +: 8];
          end
          if (n_bytes + 4 <= KEEP_W) begin
            ld_keep = keep_mask(n_bytes + 4);
            ld_user = fcs;
          end else begin
            // FCS straddles the beat boundary: finish the rest in an extra beat.
            ld_keep  = '1;
            ld_last  = 1'b0;
            ld_split = 1'b1;
            ld_rem   = 3'(n_bytes + 4 - KEEP_W);
          end
        end
        default: ;
      endcase
    end
  end

  // Extra beat: the FCS bytes that did not fit, low-aligned.
  always_comb begin
    extra_data       = '0;
    extra_data[31:0] = fcs_q >> (8 * (4 - int'(rem_q)));
    extra_keep       = keep_mask(int'(rem_q));
  end

  // Frame control, output register and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      sof_q    <= 1'b1;
      mode_q   <= MODE_COMPUTE;
      crc_q    <= '0;
      fcs_q    <= '0;
      rem_q    <= '0;
      data_p1  <= '0;
      keep_p1  <= '0;
      last_p1  <= 1'b0;
      user_p1  <= '0;
      err_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      frames_q <= '0;
      errs_q   <= '0;
    end else if (accept) begin
      data_p1 <= ld_data;
      keep_p1 <= ld_keep;
      last_p1 <= ld_last;
      user_p1 <= ld_user;
      err_p1  <= ld_err;
      vld_p1  <= 1'b1;
      sof_q   <= s_axis.tlast;
      if (sof_q) mode_q <= cur_mode;
      if (cur_mode != MODE_BYPASS) crc_q <= crc_upd;
      if (ld_split) begin
        state_q <= ST_EXTRA;
        fcs_q   <= fcs;
        rem_q   <= ld_rem;
      end
      if (ld_last) begin
        frames_q <= sat_inc(frames_q);
        if (ld_err) errs_q <= sat_inc(errs_q);
      end
    end else if (state_q == ST_EXTRA && out_free) begin
      data_p1  <= extra_data;
      keep_p1  <= extra_keep;
      last_p1  <= 1'b1;
      user_p1  <= fcs_q;
      err_p1   <= 1'b0;
      vld_p1   <= 1'b1;
      state_q  <= ST_NORMAL;
      frames_q <= sat_inc(frames_q);
    end else if (m_axis.tready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign m_axis.tdata   = data_p1;
  assign m_axis.tkeep   = keep_p1;
  assign m_axis.tlast   = last_p1;
  assign m_axis.tuser   = user_p1;
  assign m_axis.crc_err = err_p1;
  assign m_axis.tvalid  = vld_p1;
  assign stat_frames    = frames_q;
  assign stat_errs      = errs_q;

endmodule

// File: tb/tb_crc32_axis_param.sv
// Directed bench for crc32_axis_param (DATA_W = 64).
module tb_crc32_axis_param;
  import crc32_pkg::*;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [31:0] u;
    logic        e;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       cfg_mode;
  logic [31:0]      crc_init;
  logic [CNT_W-1:0] stat_frames;
  logic [CNT_W-1:0] stat_errs;

  crc32_axis_param_if #(.DATA_W(DATA_W)) s_if ();
  crc32_axis_param_if #(.DATA_W(DATA_W)) m_if ();

  crc32_axis_param #(.DATA_W(DATA_W), .RESIDUE(32'hDEBB20E3), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .cfg_mode    (cfg_mode),
    .crc_init    (crc_init),
    .stat_frames (stat_frames),
    .stat_errs   (stat_errs)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  beat_t      got[$];
  beat_t      exp[$];
  beat_t      last_got;
  logic [7:0] frm[$];
  beat_t      prev_b;
  logic       prev_stall = 1'b0;

  task automatic chk32(input string tag, input logic [31:0] g, input logic [31:0] e);
    total++;
    assert (g === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, g, e);
    end
  endtask

  task automatic chk_beat(input string tag, input beat_t g, input beat_t e);
    total++;
    assert (g === e) else begin
      bad++;
      $error("FAIL %s observed d=%h k=%h l=%b u=%h e=%b expected d=%h k=%h l=%b u=%h e=%b",
             tag, g.d, g.k, g.l, g.u, g.e, e.d, e.k, e.l, e.u, e.e);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.d = m_if.tdata;
    b.k = m_if.tkeep;
    b.l = m_if.tlast;
    b.u = m_if.tuser;
    b.e = m_if.crc_err;
    return b;
  endfunction

  // Output monitor: collect handshaken beats, check stability while stalled.
  always @(negedge clk) begin
    if (!rst && prev_stall) chk_beat("stall_hold", cur_beat(), prev_b);
    if (!rst && m_if.tvalid && m_if.tready) got.push_back(cur_beat());
    prev_stall <= m_if.tvalid && !m_if.tready && !rst;
    prev_b     <= cur_beat();
  end

  // Bit-serial reference CRC over frm[0:n-1], raw register value.
  function automatic logic [31:0] model_crc(input logic [31:0] init, input int n);
    logic [31:0] c;
    logic        fb;
    c = init;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ frm[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  // Expected beats: byte stream (plus FCS when appending) chopped into 8-byte beats.
  task automatic expect_frame(input int mode, input logic [31:0] init, input int n);
    logic [7:0]  st[$];
    logic [31:0] c;
    logic [31:0] f;
    int          nb;
    beat_t       b;
    c = model_crc(init, n);
    f = ~c;
    for (int i = 0; i < n; i++) st.push_back(frm[i]);
    if (mode == 1) for (int j = 0; j < 4; j++) st.push_back(f[8*j +: 8]);
    nb = (st.size() == 0) ? 1 : (st.size() + 7) / 8;
    for (int bi = 0; bi < nb; bi++) begin
      b = '0;
      for (int j = 0; j < 8; j++) begin
        if (8*bi + j < st.size()) begin
          b.d[8*j +: 8] = st[8*bi + j];
          b.k[j] = 1'b1;
        end
      end
      if (bi == nb - 1) begin
        b.l = 1'b1;
        if (mode != 3) b.u = f;
        if (mode == 2) b.e = (c != 32'hDEBB20E3);
      end
      exp.push_back(b);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    int w;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    w = 0;
    while (!s_if.tready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      total++;
      bad++;
      $display("FAIL send_timeout observed tready=0 for 100 cycles expected tready=1");
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n);
    int          nb;
    logic [63:0] d;
    logic [7:0]  k;
    nb = (n == 0) ? 1 : (n + 7) / 8;
    for (int bi = 0; bi < nb; bi++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 8; j++) begin
        if (8*bi + j < n) begin
          d[8*j +: 8] = frm[8*bi + j];
          k[j] = 1'b1;
        end
      end
      send(d, k, bi == nb - 1);
    end
  endtask

  task automatic check_out(input string tag);
    int w;
    w = 0;
    while (got.size() < exp.size() && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    chk32({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk_beat($sformatf("%s_beat%0d", tag, i), got[i], exp[i]);
    if (got.size() > 0) last_got = got[got.size() - 1];
    else last_got = '0;
    got.delete();
    exp.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic load_str(input string s);
    frm.delete();
    for (int i = 0; i < s.len(); i++) frm.push_back(s[i]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    cfg_mode     = 2'd0;
    crc_init     = 32'hFFFFFFFF;
    s_if.tdata   = '0;
    s_if.tkeep   = '0;
    s_if.tvalid  = 1'b0;
    s_if.tlast   = 1'b0;
    s_if.tuser   = '0;
    s_if.crc_err = 1'b0;
    m_if.tready  = 1'b1;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    chk32("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk32("rst_tdata", m_if.tdata[31:0], 32'd0);
    chk32("rst_tkeep", 32'(m_if.tkeep), 32'd0);
    chk32("rst_tlast", 32'(m_if.tlast), 32'd0);
    chk32("rst_tuser", m_if.tuser, 32'd0);
    chk32("rst_err", 32'(m_if.crc_err), 32'd0);
    chk32("rst_frames", 32'(stat_frames), 32'd0);
    chk32("rst_errs", 32'(stat_errs), 32'd0);
    chk32("rst_sready", 32'(s_if.tready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk32("post_rst_sready", 32'(s_if.tready), 32'd1);
    @(posedge clk);
    #1;

    // Mode 0: "123456789"
    cfg_mode = 2'd0;
    send(64'h3837363534333231, 8'hFF, 1'b0);
    send(64'h0000000000000039, 8'h01, 1'b1);
    exp.push_back('{d:64'h3837363534333231, k:8'hFF, l:1'b0, u:32'h0, e:1'b0});
    exp.push_back('{d:64'h0000000000000039, k:8'h01, l:1'b1, u:32'hCBF43926, e:1'b0});
    check_out("m0_check_string");
    chk32("m0_frames", 32'(stat_frames), 32'd1);

    // Mode 1: same frame, FCS fits in last beat
    cfg_mode = 2'd1;
    send(64'h3837363534333231, 8'hFF, 1'b0);
    send(64'h0000000000000039, 8'h01, 1'b1);
    exp.push_back('{d:64'h3837363534333231, k:8'hFF, l:1'b0, u:32'h0, e:1'b0});
    exp.push_back('{d:64'h000000CBF4392639, k:8'h1F, l:1'b1, u:32'hCBF43926, e:1'b0});
    check_out("m1_fit");
    chk32("m1_frames", 32'(stat_frames), 32'd2);

    // Mode 2: appended frame checks clean
    cfg_mode = 2'd2;
    send(64'h3837363534333231, 8'hFF, 1'b0);
    send(64'h000000CBF4392639, 8'h1F, 1'b1);
    exp.push_back('{d:64'h3837363534333231, k:8'hFF, l:1'b0, u:32'h0, e:1'b0});
    exp.push_back('{d:64'h000000CBF4392639, k:8'h1F, l:1'b1, u:32'h2144DF1C, e:1'b0});
    check_out("m2_good");
    chk32("m2_good_errs", 32'(stat_errs), 32'd0);

    // Mode 2: bit 0 of byte 3 flipped
    frm = '{8'h31, 8'h32, 8'h33, 8'h35, 8'h35, 8'h36, 8'h37, 8'h38,
            8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    send_frame(13);
    expect_frame(2, 32'hFFFFFFFF, 13);
    check_out("m2_bad");
    chk32("m2_bad_err", 32'(last_got.e), 32'd1);
    chk32("m2_bad_errs", 32'(stat_errs), 32'd1);
    chk32("m2_bad_frames", 32'(stat_frames), 32'd4);

    // Mode 1 split, last tkeep FF: tready drops for exactly one cycle
    cfg_mode = 2'd1;
    frm.delete();
    for (int i = 0; i < 16; i++) frm.push_back(8'(i));
    send_frame(16);
    @(negedge clk);
    chk32("split8_sready_low", 32'(s_if.tready), 32'd0);
    @(negedge clk);
    chk32("split8_sready_back", 32'(s_if.tready), 32'd1);
    @(posedge clk);
    #1;
    expect_frame(1, 32'hFFFFFFFF, 16);
    check_out("split8");
    chk32("split8_extra_keep", 32'(last_got.k), 32'h0F);

    // Mode 1 split, last tkeep 1F
    frm.delete();
    for (int i = 0; i < 13; i++) frm.push_back(8'(8'h20 + i));
    send_frame(13);
    expect_frame(1, 32'hFFFFFFFF, 13);
    check_out("split5");
    chk32("split5_extra_keep", 32'(last_got.k), 32'h01);

    // Backpressure 1-0-0-1 across an append-split frame
    frm.delete();
    for (int i = 0; i < 13; i++) frm.push_back(8'(8'h40 + i));
    fork
      send_frame(13);
      begin
        for (int c = 0; c < 24; c++) begin
          m_if.tready = !((c % 4) == 1 || (c % 4) == 2);
          @(posedge clk);
          #1;
        end
        m_if.tready = 1'b1;
      end
    join
    expect_frame(1, 32'hFFFFFFFF, 13);
    check_out("bp_split");

    // Back-to-back: bypass then compute; mid-frame config changes ignored
    cfg_mode = 2'd3;
    crc_init = 32'hFFFFFFFF;
    send(64'h3837363534333231, 8'hFF, 1'b0);
    cfg_mode = 2'd1;
    crc_init = 32'h0;
    send(64'h0000000000000039, 8'h01, 1'b1);
    cfg_mode = 2'd0;
    crc_init = 32'hFFFFFFFF;
    send(64'h3837363534333231, 8'hFF, 1'b0);
    cfg_mode = 2'd2;
    crc_init = 32'h0;
    send(64'h0000000000000039, 8'h01, 1'b1);
    exp.push_back('{d:64'h3837363534333231, k:8'hFF, l:1'b0, u:32'h0, e:1'b0});
    exp.push_back('{d:64'h0000000000000039, k:8'h01, l:1'b1, u:32'h0, e:1'b0});
    exp.push_back('{d:64'h3837363534333231, k:8'hFF, l:1'b0, u:32'h0, e:1'b0});
    exp.push_back('{d:64'h0000000000000039, k:8'h01, l:1'b1, u:32'hCBF43926, e:1'b0});
    check_out("b2b_modes");
    chk32("b2b_frames", 32'(stat_frames), 32'd9);

    // tkeep = 0 on a single-beat frame
    cfg_mode = 2'd1;
    crc_init = 32'hFFFFFFFF;
    send(64'hAAAAAAAAAAAAAAAA, 8'h00, 1'b1);
    exp.push_back('{d:64'hAAAAAAAA00000000, k:8'h0F, l:1'b1, u:32'h0, e:1'b0});
    check_out("keep0_append");
    cfg_mode = 2'd0;
    crc_init = 32'h00000000;
    send(64'h5555555555555555, 8'h00, 1'b1);
    exp.push_back('{d:64'h5555555555555555, k:8'h00, l:1'b1, u:32'hFFFFFFFF, e:1'b0});
    check_out("keep0_single_init");

    // Longer known vector
    crc_init = 32'hFFFFFFFF;
    load_str("The quick brown fox jumps over the lazy dog");
    send_frame(43);
    expect_frame(0, 32'hFFFFFFFF, 43);
    check_out("fox");
    chk32("fox_crc", last_got.u, 32'h414FA339);

    // Reset mid-frame after beat0
    cfg_mode = 2'd0;
    crc_init = 32'h12345678;
    send(64'h3837363534333231, 8'hFF, 1'b0);
    exp.push_back('{d:64'h3837363534333231, k:8'hFF, l:1'b0, u:32'h0, e:1'b0});
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk32("midrst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk32("midrst_tdata", m_if.tdata[63:32], 32'd0);
    chk32("midrst_tuser", m_if.tuser, 32'd0);
    chk32("midrst_frames", 32'(stat_frames), 32'd0);
    chk32("midrst_sready", 32'(s_if.tready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    crc_init = 32'hFFFFFFFF;
    send(64'h3837363534333231, 8'hFF, 1'b0);
    send(64'h0000000000000039, 8'h01, 1'b1);
    exp.push_back('{d:64'h3837363534333231, k:8'hFF, l:1'b0, u:32'h0, e:1'b0});
    exp.push_back('{d:64'h0000000000000039, k:8'h01, l:1'b1, u:32'hCBF43926, e:1'b0});
    check_out("after_rst");
    chk32("after_rst_frames", 32'(stat_frames), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc32_axis_param.md
Name: crc32_axis_param

Overview:
Parametrised successor to the fixed 64-bit 10G CRC32 pipeline. It computes IEEE 802.3 CRC32 (reflected polynomial 0xEDB88320) over an AXI-Stream frame of configurable width. Per frame it runs one of four modes: compute, append FCS, check FCS, or bypass. It sits between the MAC framing logic and the PCS/user-side streams, on both the TX path (append) and the RX path (check).

Parameters:
DATA_W, 64, tdata width in bits; multiple of 8, minimum 32 (64/128/256 supported).
KEEP_W, DATA_W/8, tkeep width; derived, not overridden.
RESIDUE, 32'hDEBB20E3, expected raw CRC register value after data plus a valid FCS.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  DATA_W  input data; byte 0 = tdata[7:0] is first on the wire
s_axis_tkeep  in  KEEP_W  contiguous low-aligned byte enables; all ones except on tlast
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  end of frame
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_W  output data
m_axis_tkeep  out  KEEP_W  output byte enables
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  output end of frame
m_axis_tuser  out  32  final CRC (~register); valid only on the tlast beat, else 0
m_axis_crc_err  out  1  check-mode error flag; valid only on the tlast beat, else 0
m_axis_tready  in  1  output ready
cfg_mode  in  2  0 = compute, 1 = append FCS, 2 = check, 3 = bypass; sampled on first beat of frame
crc_init  in  32  CRC register seed; sampled on first beat of frame
stat_frames  out  CNT_W  frames completed; saturating
stat_errs  out  CNT_W  check-mode CRC failures; saturating

Behaviour:
- Reset: all m_axis_* outputs 0, stat_* 0, s_axis_tready 0 during rst and 1 on the first cycle after. State NORMAL, sof = 1.
- Latency: one registered output stage. An input beat accepted at cycle N appears on m_axis at cycle N+1 if the output was free.
- Handshake: s_axis_tready = (!m_axis_tvalid || m_axis_tready) && state == NORMAL. The output holds all fields stable while tvalid && !tready.
- Frame start: the beat accepted with sof = 1 latches cfg_mode and crc_init. Changes to either mid-frame are ignored. sof is set after an accepted tlast beat.
- CRC datapath: a single-cycle combinational byte-masked update over KEEP_W bytes. Next register = f(crc_reg or latched init on sof, data, tkeep). LSB-first per byte.
- Mode 0: data passes unchanged; tuser = ~crc on tlast.
- Mode 2: data passes unchanged; tuser = ~crc; crc_err = (raw crc != RESIDUE).
- Mode 3: data passes unchanged; tuser = 0, crc_err = 0, no CRC update. The frame still counts in stat_frames.
- Mode 1, last beat with n valid bytes:
  - If n+4 <= KEEP_W: FCS bytes (~crc, little-endian) go into bytes n..n+3. tkeep is extended by 4 bits; one beat is emitted.
  - Else: the beat is emitted with tkeep all ones, carrying the first KEEP_W-n FCS bytes, with tlast = 0. The remaining n+4-KEEP_W bytes are held and the state goes to EXTRA.
- State EXTRA: s_axis_tready = 0. When the output register frees, it loads the extra beat (remaining FCS bytes low-aligned, tkeep with that many ones, tlast = 1, tuser = ~crc), then returns to NORMAL.
- Statistics: stat_frames increments when a tlast beat is loaded into the output register. stat_errs increments in the same cycle if crc_err. Both saturate at all ones.
- Boundaries:
  - A single-beat frame (sof and tlast together) uses crc_init directly.
  - Output stall during EXTRA holds the extra data indefinitely.
  - rst mid-frame drops the frame silently, with no partial emission afterwards.
  - tkeep = 0 on a tlast beat is treated as n = 0 (append FCS in bytes 0..3).

Decomposition:
- Shared package crc32_pkg: CRC32_POLY_REFL = 32'hEDB88320, CRC32_RESIDUE, mode encodings (MODE_COMPUTE, MODE_APPEND, MODE_CHECK, MODE_BYPASS), and the byte-update function crc32_byte.
- Sub-module crc32_comb_update (parameter KEEP_W): a purely combinational masked multi-byte update, reused by the RX/TX wrappers.
- State machine, output register, FCS insertion/shifting and counters stay in the top module.

Test Plan:
- Mode 0, DATA_W=64, init FFFFFFFF; "123456789" sent as beat0 tdata 0x3837363534333231 tkeep FF, beat1 tdata 0x39 tkeep 01 tlast -> tuser 0xCBF43926 on beat1, stat_frames 1.
- Mode 1, same frame -> beat1 tdata[39:0] 0xCBF4392639, tkeep 1F, tlast; no extra beat; beat0 unchanged.
- Mode 1 split: 16-byte frame, last tkeep FF -> last input beat out with tlast 0; extra beat tkeep 0F carrying ~crc; s_axis_tready low exactly one cycle. Repeat with last tkeep 1F -> tkeep FF with 3 FCS bytes, then extra tkeep 01.
- Mode 2: feed mode-1 output back -> crc_err 0, stat_errs 0. Flip bit 0 of byte 3 -> crc_err 1, stat_errs 1.
- Backpressure: m_axis_tready toggles 1-0-0-1 across an append-split frame -> output stable while stalled; no beat lost or duplicated; CRC unchanged. Back-to-back frames with different cfg_mode -> each frame uses its own latched mode.
- Reset mid-frame after beat0 -> all outputs 0; next frame's CRC is computed from fresh crc_init, matching the golden model.
